// File: rtl/thor2024_fpu_issue_queue_if.sv
// Issue-queue bus: upstream enqueue port plus the FPU issue/completion port.
// The queue itself uses the slave view; whatever drives ops in and plays
// the FPU uses the master view.
interface thor2024_fpu_issue_queue_if #(
  parameter int IW = 41,
  parameter int TW = 5
);
  // upstream (decode/rename) side
  logic          enq_v;
  logic          enq_fpu;
  logic [IW-1:0] enq_instr;
  logic [TW-1:0] enq_tag;
  logic          enq_rdy;
  // FPU side
  logic          fpu_req;
  logic [IW-1:0] fpu_instr;
  logic [TW-1:0] fpu_tag;
  logic          fpu_ack;
  logic          fpu_done;

  modport master (
    output enq_v, enq_fpu, enq_instr, enq_tag,
    input  enq_rdy,
    input  fpu_req, fpu_instr, fpu_tag,
    output fpu_ack, fpu_done
  );

  modport slave (
    input  enq_v, enq_fpu, enq_instr, enq_tag,
    output enq_rdy,
    output fpu_req, fpu_instr, fpu_tag,
    input  fpu_ack, fpu_done
  );
endinterface

// File: rtl/thor2024_fpu_issue_queue.sv
// In-order FPU issue queue. Holds decoded FPU ops between rename and the FPU,
// hands the head op to the FPU over a req/ack handshake, and throttles issue
// so that no more than MAX_INFLIGHT ops are outstanding in the FPU.
module thor2024_fpu_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int IW           = 41,
  parameter int TW           = 5,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  thor2024_fpu_issue_queue_if.slave  bus_io,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [2:0]                 inflight_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage: instruction and ROB tag kept side by side.
  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [TW-1:0] tag_mem_q   [DEPTH];

  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [2:0]    inflight_q, inflight_d;
  logic          err_q,      err_d;

  logic          enq_rdy_s;
  logic          fpu_req_s;
  logic          enq_s;
  logic          iss_s;

  // Handshake qualifiers, all derived from registered state (no bypass paths).
  always_comb begin
    enq_rdy_s = (count_q < CW'(DEPTH));
    fpu_req_s = (count_q != {CW{1'b0}}) && (inflight_q < 3'(MAX_INFLIGHT));
    enq_s     = bus_io.enq_v & bus_io.enq_fpu & enq_rdy_s & ~flush_i;
    iss_s     = fpu_req_s & bus_io.fpu_ack;
  end

  // Next-state for pointers, occupancy, in-flight counter and error flag.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    // A flush empties the queue; an op issued in the same cycle has already
    // left it, so only the in-flight bookkeeping still sees that issue.
    if (flush_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (iss_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, iss_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Completion with nothing outstanding is a protocol error; the counter
    // is held at zero rather than wrapping.
    case ({iss_s, bus_io.fpu_done})
      2'b10: inflight_d = inflight_q + 3'd1;
      2'b01: begin
        if (inflight_q != 3'd0) begin
          inflight_d = inflight_q - 3'd1;
        end else begin
          inflight_d = 3'd0;
          err_d      = 1'b1;
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers; reset wins over flush, enqueue, issue and completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      inflight_q <= 3'd0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Entry write; storage needs no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      instr_mem_q[wr_ptr_q] <= bus_io.enq_instr;
      tag_mem_q[wr_ptr_q]   <= bus_io.enq_tag;
    end
  end

  // Output drive: head entry and status straight from registered state.
  always_comb begin
    bus_io.enq_rdy   = enq_rdy_s;
    bus_io.fpu_req   = fpu_req_s;
    bus_io.fpu_instr = instr_mem_q[rd_ptr_q];
    bus_io.fpu_tag   = tag_mem_q[rd_ptr_q];
    count_o          = count_q;
    inflight_o       = inflight_q;
    err_o            = err_q;
  end

endmodule
